matmul_tile_sequencer: RTL and testbench

//  Sequences the combinational matrix_multiplication_accumulation datapath over multi-tile jobs.
//  Per job: accept descriptor, stream k_tiles (A,B) tile pairs, accumulate D = sum(A_t*B_t) + C0.

---
 rtl/matmul_pkg.sv | 14 +
 rtl/matmul_tile_sequencer_if.sv | 49 ++++
 rtl/matrix_multiplication_accumulation.sv | 51 +++++
 rtl/matmul_tile_sequencer.sv | 102 ++++++++++
 tb/tb_matmul_tile_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and width helpers for the matmul tile sequencer
// Purpose: FSM state type and accumulator width rule used by the sequencer,
//   its bus interface and the multiply-accumulate datapath.
// Ports: none (package).
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} seq_state_t;

  // Accumulator width for P-bit signed operands.
  function automatic int acc_w(input int p);
    return 4 * p;
  endfunction

endpackage

// File: rtl/matmul_tile_sequencer_if.sv
// rtl/matmul_tile_sequencer_if.sv - job/tile/result handshake bundle for the tile sequencer
// Purpose: groups the three valid/ready channels of the sequencer.
// Signals:
//   job_*  : descriptor channel (valid/ready, k_tiles, c_init, c)
//   tile_* : tile pair channel (valid/ready, a, b)
//   res_*  : result channel (valid/ready, d)
// Modports: master = upstream/downstream side, slave = sequencer side.
interface matmul_tile_sequencer_if
  import matmul_pkg::*;
#(
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K      = 2,
  parameter int P      = 8,
  parameter int MAX_KT = 16
);
  localparam int ACC_W = acc_w(P);
  localparam int KT_W  = $clog2(MAX_KT + 1);

  logic                              job_valid;
  logic                              job_ready;
  logic [KT_W-1:0]                   job_k_tiles;
  logic                              job_c_init;
  logic [M-1:0][N-1:0][ACC_W-1:0]    job_c;

  logic                              tile_valid;
  logic                              tile_ready;
  logic [M-1:0][K-1:0][P-1:0]        tile_a;
  logic [K-1:0][N-1:0][P-1:0]        tile_b;

  logic                              res_valid;
  logic                              res_ready;
  logic [M-1:0][N-1:0][ACC_W-1:0]    res_d;

  modport master (
    output job_valid, job_k_tiles, job_c_init, job_c,
    output tile_valid, tile_a, tile_b,
    output res_ready,
    input  job_ready, tile_ready, res_valid, res_d
  );

  modport slave (
    input  job_valid, job_k_tiles, job_c_init, job_c,
    input  tile_valid, tile_a, tile_b,
    input  res_ready,
    output job_ready, tile_ready, res_valid, res_d
  );

endinterface

// File: rtl/matrix_multiplication_accumulation.sv
// rtl/matrix_multiplication_accumulation.sv - combinational D = A*B + C tile datapath
// Purpose: signed MxK by KxN multiply with accumulator add, wrapping mod 2^ACC_W.
// Ports:
//   a : in  [M][K]P      signed A tile
//   b : in  [K][N]P      signed B tile
//   c : in  [M][N]ACC_W  signed accumulator operand
//   d : out [M][N]ACC_W  signed result
// TREE selects summation order (0: chain from C, else: products first, C last);
// both give identical bits because all sums wrap at ACC_W.
module matrix_multiplication_accumulation
  import matmul_pkg::*;
#(
  parameter int M    = 2,
  parameter int N    = 2,
  parameter int K    = 2,
  parameter int P    = 8,
  parameter int TREE = 0
) (
  input  logic [M-1:0][K-1:0][P-1:0]             a,
  input  logic [K-1:0][N-1:0][P-1:0]             b,
  input  logic [M-1:0][N-1:0][acc_w(P)-1:0]      c,
  output logic [M-1:0][N-1:0][acc_w(P)-1:0]      d
);
  localparam int ACC_W = acc_w(P);

  logic signed [2*P-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;

  always_comb begin
    d        = '0;
    prod     = '0;
    prod_ext = '0;
    sum      = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        sum = (TREE == 0) ? $signed(c[i][j]) : '0;
        for (int k = 0; k < K; k++) begin
          prod     = $signed(a[i][k]) * $signed(b[k][j]);
          prod_ext = prod;  // sign-extends the 2P-bit product
          sum      = sum + prod_ext;
        end
        if (TREE != 0) begin
          sum = sum + $signed(c[i][j]);
        end
        d[i][j] = sum;
      end
    end
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// rtl/matmul_tile_sequencer.sv - sequences multi-tile matmul-accumulate jobs over the datapath
// Purpose: accepts a job descriptor, accumulates k_tiles (A,B) pairs into a
//   registered MxN accumulator, then presents the accumulator as the result.
// Ports:
//   clk      : in  clock, rising edge
//   rst_n    : in  asynchronous active-low reset
//   bus      : slave side of the job/tile/result handshakes
//   busy     : out high whenever a job is in flight (not IDLE)
//   tile_cnt : out tiles accepted in the current job
module matmul_tile_sequencer
  import matmul_pkg::*;
#(
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K      = 2,
  parameter int P      = 8,
  parameter int TREE   = 0,
  parameter int MAX_KT = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  matmul_tile_sequencer_if.slave             bus,
  output logic                               busy,
  output logic [$clog2(MAX_KT+1)-1:0]        tile_cnt
);
  localparam int ACC_W = acc_w(P);
  localparam int KT_W  = $clog2(MAX_KT + 1);

  seq_state_t                     state_q, state_d;
  logic [M-1:0][N-1:0][ACC_W-1:0] acc_q, dp_d;
  logic [KT_W-1:0]                kt_q, cnt_q, k_clamped;
  logic                           job_rdy, tile_rdy, res_vld;
  logic                           last_tile;

  matrix_multiplication_accumulation #(
    .M(M), .N(N), .K(K), .P(P), .TREE(TREE)
  ) u_dp (
    .a(bus.tile_a),
    .b(bus.tile_b),
    .c(acc_q),
    .d(dp_d)
  );

  assign k_clamped = (bus.job_k_tiles > KT_W'(MAX_KT)) ? KT_W'(MAX_KT) : bus.job_k_tiles;
  // kt_q is never 0 while in ACCUM, so kt_q-1 cannot underflow there.
  assign last_tile = (cnt_q == kt_q - KT_W'(1));

  always_comb begin
    state_d  = state_q;
    job_rdy  = 1'b0;
    tile_rdy = 1'b0;
    res_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        job_rdy = 1'b1;
        if (bus.job_valid) begin
          state_d = (k_clamped == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        tile_rdy = 1'b1;
        if (bus.tile_valid && last_tile) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res_vld = 1'b1;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      kt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (job_rdy && bus.job_valid) begin
        kt_q  <= k_clamped;
        acc_q <= bus.job_c_init ? bus.job_c : '0;
        cnt_q <= '0;
      end else if (tile_rdy && bus.tile_valid) begin
        acc_q <= dp_d;
        cnt_q <= cnt_q + KT_W'(1);
      end
    end
  end

  assign bus.job_ready  = job_rdy;
  assign bus.tile_ready = tile_rdy;
  assign bus.res_valid  = res_vld;
  assign bus.res_d      = acc_q;
  assign busy           = (state_q != IDLE);
  assign tile_cnt       = cnt_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb/tb_matmul_tile_sequencer.sv - self-checking bench for matmul_tile_sequencer
module tb_matmul_tile_sequencer;
  localparam int M = 2, N = 2, K = 2, P = 8, MAX_KT = 16;
  localparam int ACC_W = 32, KT_W = 5;
  typedef logic [M-1:0][N-1:0][ACC_W-1:0] mat_t;
  typedef logic [M-1:0][K-1:0][P-1:0]     a_t;
  typedef logic [K-1:0][N-1:0][P-1:0]     b_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy;
  logic [KT_W-1:0] tile_cnt;

  matmul_tile_sequencer_if #(.M(M), .N(N), .K(K), .P(P), .MAX_KT(MAX_KT)) bus ();

  matmul_tile_sequencer #(
    .M(M), .N(N), .K(K), .P(P), .TREE(0), .MAX_KT(MAX_KT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL timeout_%s: handshake not seen, required within 200 cycles", nm);
  endtask

  function automatic mat_t mk(input int e00, input int e01, input int e10, input int e11);
    mat_t v;
    v[0][0] = ACC_W'(e00); v[0][1] = ACC_W'(e01);
    v[1][0] = ACC_W'(e10); v[1][1] = ACC_W'(e11);
    return v;
  endfunction

  // Transaction-level model: phase of the job protocol, expected
  // accumulator contents (plain integer matrix arithmetic) and tile count.
  int     ph;      // 0 awaiting job, 1 taking tiles, 2 presenting result
  longint macc[M][N];
  int     mcnt, mleft;

  function automatic mat_t model_res();
    mat_t v;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        longint x;
        x = macc[i][j];
        v[i][j] = x[ACC_W-1:0];
      end
    return v;
  endfunction

  initial begin
    ph = 0; mcnt = 0; mleft = 0;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) macc[i][j] = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_job_ready", bus.job_ready, 1'b1);
      chk("rst_tile_ready", bus.tile_ready, 1'b0);
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_d", bus.res_d, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tile_cnt", tile_cnt, '0);
      ph = 0; mcnt = 0; mleft = 0;
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) macc[i][j] = 0;
    end else begin
      chk("job_ready", bus.job_ready, ph == 0);
      chk("tile_ready", bus.tile_ready, ph == 1);
      chk("res_valid", bus.res_valid, ph == 2);
      chk("busy", busy, ph != 0);
      chk("tile_cnt", tile_cnt, mcnt[KT_W-1:0]);
      chk("res_d", bus.res_d, model_res());
      case (ph)
        0: if (bus.job_valid) begin
          int k;
          k = int'(bus.job_k_tiles);
          if (k > MAX_KT) k = MAX_KT;
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
              macc[i][j] = bus.job_c_init ? longint'($signed(bus.job_c[i][j])) : 0;
          mcnt = 0;
          mleft = k;
          ph = (k == 0) ? 2 : 1;
        end
        1: if (bus.tile_valid) begin
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
              for (int k = 0; k < K; k++)
                macc[i][j] += longint'($signed(bus.tile_a[i][k])) * longint'($signed(bus.tile_b[k][j]));
          mcnt++;
          mleft--;
          if (mleft == 0) ph = 2;
        end
        default: if (bus.res_ready) ph = 0;
      endcase
    end
  end

  a_t ta[MAX_KT];
  b_t tbm[MAX_KT];

  task automatic send_job(input int k, input bit ci, input mat_t c);
    int t;
    t = 0;
    bus.job_valid = 1'b1;
    bus.job_k_tiles = KT_W'(k);
    bus.job_c_init = ci;
    bus.job_c = c;
    do begin @(negedge clk); t++; end while (!bus.job_ready && t < 200);
    if (!bus.job_ready) timeout("job");
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    bus.job_c = {$urandom, $urandom, $urandom, $urandom};
    bus.job_k_tiles = KT_W'($urandom);
  endtask

  task automatic send_tile(input a_t a, input b_t b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.tile_valid = 1'b1;
    bus.tile_a = a;
    bus.tile_b = b;
    do begin @(negedge clk); t++; end while (!bus.tile_ready && t < 200);
    if (!bus.tile_ready) timeout("tile");
    @(posedge clk); #1;
    bus.tile_valid = 1'b0;
    bus.tile_a = a_t'($urandom);
    bus.tile_b = b_t'($urandom);
  endtask

  task automatic get_result(input int delay, output mat_t res, output logic [KT_W-1:0] cnt);
    int t;
    t = 0;
    while (!bus.res_valid && t < 200) begin @(negedge clk); t++; end
    if (!bus.res_valid) timeout("res");
    repeat (delay) begin
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.job_valid = 1'($urandom);
      bus.tile_valid = 1'($urandom);
      bus.tile_a = a_t'($urandom);
    end
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    bus.tile_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    res = bus.res_d;
    cnt = tile_cnt;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic run_job(input int k, input bit ci, input mat_t c, input int n_tiles,
                         input int max_gap, input int delay,
                         output mat_t res, output logic [KT_W-1:0] cnt);
    send_job(k, ci, c);
    for (int t = 0; t < n_tiles; t++) send_tile(ta[t], tbm[t], $urandom_range(0, max_gap));
    get_result(delay, res, cnt);
  endtask

  task automatic load_t1(input int idx);
    ta[idx][0][0] = 8'd1; ta[idx][0][1] = 8'd2; ta[idx][1][0] = 8'd3; ta[idx][1][1] = 8'd4;
    tbm[idx][0][0] = 8'd5; tbm[idx][0][1] = 8'd6; tbm[idx][1][0] = 8'd7; tbm[idx][1][1] = 8'd8;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion before 2ms");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    mat_t res;
    logic [KT_W-1:0] cnt;
    int kraw, nt;
    bus.job_valid = 1'b0; bus.job_k_tiles = '0; bus.job_c_init = 1'b0; bus.job_c = '0;
    bus.tile_valid = 1'b0; bus.tile_a = '0; bus.tile_b = '0; bus.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // k=1 basic product
    load_t1(0);
    run_job(1, 1'b0, '0, 1, 0, 0, res, cnt);
    chk("t1_res", res, mk(19, 22, 43, 50));
    chk("t1_cnt", cnt, 5'd1);

    // k=2 with gaps, C init of ones
    load_t1(0); load_t1(1);
    run_job(2, 1'b1, mk(1, 1, 1, 1), 2, 3, 0, res, cnt);
    chk("t2_res", res, mk(39, 45, 87, 101));
    chk("t2_cnt", cnt, 5'd2);

    // k=0 returns initial C
    run_job(0, 1'b1, mk(7, -3, 0, 2), 0, 0, 0, res, cnt);
    chk("t3_res", res, mk(7, -3, 0, 2));
    chk("t3_cnt", cnt, 5'd0);

    // k=16 of all -128
    for (int t = 0; t < MAX_KT; t++) begin
      ta[t] = {M*K{8'h80}};
      tbm[t] = {K*N{8'h80}};
    end
    run_job(16, 1'b0, '0, 16, 1, 0, res, cnt);
    chk("t4_res", res, mk(524288, 524288, 524288, 524288));
    chk("t4_cnt", cnt, 5'd16);

    // result held 5 cycles under backpressure
    load_t1(0);
    run_job(1, 1'b0, '0, 1, 0, 5, res, cnt);
    chk("t5_res", res, mk(19, 22, 43, 50));

    // reset after 1 of 3 tiles, then a clean k=1 job
    send_job(3, 1'b1, mk(100, 200, 300, 400));
    send_tile(ta[0], tbm[0], 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(1, 1'b0, '0, 1, 0, 0, res, cnt);
    chk("t6_res", res, mk(19, 22, 43, 50));

    // k above MAX_KT clamps to MAX_KT
    for (int t = 0; t < MAX_KT; t++) begin
      ta[t] = a_t'($urandom);
      tbm[t] = b_t'($urandom);
    end
    run_job(20, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 16, 1, 1, res, cnt);
    chk("t7_cnt", cnt, 5'd16);

    // randomized jobs checked by the model every cycle
    for (int j = 0; j < 30; j++) begin
      kraw = $urandom_range(0, 20);
      nt = (kraw > MAX_KT) ? MAX_KT : kraw;
      for (int t = 0; t < MAX_KT; t++) begin
        ta[t] = a_t'($urandom);
        tbm[t] = b_t'($urandom);
      end
      run_job(kraw, 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, nt,
              $urandom_range(0, 2), $urandom_range(0, 3), res, cnt);
      chk("rand_cnt", cnt, nt[KT_W-1:0]);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
